// File: rtl/fp_pkg.sv
// ============================================================================
//  Module  : fp_pkg
//  Purpose : Shared constants for the FP divide issue path: operand and
//            rounding-mode widths, rounding-mode encodings and the issue FSM
//            state encoding.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int FP_W = 32;
  localparam int RM_W = 2;

  // Rounding-mode encodings carried on id_rm / div_rm
  localparam logic [RM_W-1:0] RM_RNE = 2'd0;
  localparam logic [RM_W-1:0] RM_RTZ = 2'd1;
  localparam logic [RM_W-1:0] RM_RDN = 2'd2;
  localparam logic [RM_W-1:0] RM_RUP = 2'd3;

  // Issue FSM state encoding
  localparam int            ST_W     = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_START = 3'd1;
  localparam logic [ST_W-1:0] ST_ITER  = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_WB    = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_ITER  = ST_ITER,
    S_DRAIN = ST_DRAIN,
    S_WB    = ST_WB
  } fdiv_state_e;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fdiv_issue_ctrl.sv
// ============================================================================
//  Module  : fdiv_issue_ctrl
//  Purpose : Issue/interlock stage between ID and the Newton FP divider.
//            Captures one fdiv, pulses the divider start, holds the op in
//            flight through iteration and the divider tail, writes the
//            quotient back with its destination tag, and stalls ID on
//            structural (second fdiv) and RAW (reads of the pending tag)
//            hazards.
//  Revision: 1.0  initial release
//
//  Parameters
//    DRAIN_CYC : cycles from div_busy falling to a valid div_s
//    TAG_W     : destination register index width
//
//  Ports
//    clk, clr            clock (rising edge) / synchronous active-high reset
//    id_fdiv             ID decodes an fdiv
//    id_a, id_b, id_rm   dividend, divisor, rounding mode from ID
//    id_fd               fdiv destination register
//    id_rs_fs, id_rs_ft  FP sources read by the current ID instruction
//    id_rs_use           [0]=fs read valid, [1]=ft read valid
//    div_busy, div_s     divider iterating flag / divider result
//    div_a, div_b, div_rm registered operands to the divider
//    div_fdiv            one-cycle start pulse
//    div_ena             divider pipeline enable (op in flight)
//    stall_id            freeze IF/ID
//    wb_we, wb_fd, wb_data  one-cycle FP regfile write port
//    fwd_fs, fwd_ft      (FDIV_BYPASS_EN only) forward wb_data to ID operands
//
//  Build option
//    FDIV_BYPASS_EN : when defined, RAW stalls are released in the WB cycle
//                     and fwd_fs/fwd_ft steer the write data into ID.
// ============================================================================
`default_nettype none

module fdiv_issue_ctrl
  import fp_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             id_fdiv,
  input  logic [FP_W-1:0]  id_a,
  input  logic [FP_W-1:0]  id_b,
  input  logic [RM_W-1:0]  id_rm,
  input  logic [TAG_W-1:0] id_fd,
  input  logic [TAG_W-1:0] id_rs_fs,
  input  logic [TAG_W-1:0] id_rs_ft,
  input  logic [1:0]       id_rs_use,
  input  logic             div_busy,
  input  logic [FP_W-1:0]  div_s,
  output logic [FP_W-1:0]  div_a,
  output logic [FP_W-1:0]  div_b,
  output logic [RM_W-1:0]  div_rm,
  output logic             div_fdiv,
  output logic             div_ena,
  output logic             stall_id,
  output logic             wb_we,
  output logic [TAG_W-1:0] wb_fd,
  output logic [FP_W-1:0]  wb_data
`ifdef FDIV_BYPASS_EN
  ,
  output logic             fwd_fs,
  output logic             fwd_ft
`endif
);

  localparam int               CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

  // A read of the pending tag is a hazard, except register 0 which is
  // hardwired and never written.
  function automatic logic raw_hit(input logic             use_v,
                                   input logic [TAG_W-1:0] rs,
                                   input logic [TAG_W-1:0] tag);
    return use_v && (rs != '0) && (rs == tag);
  endfunction

  fdiv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [FP_W-1:0]  div_a_q, div_a_d;
  logic [FP_W-1:0]  div_b_q, div_b_d;
  logic [RM_W-1:0]  div_rm_q, div_rm_d;

  logic w_in_wb;
  logic w_raw;
  logic w_raw_stall;

  assign w_in_wb = (state_q == S_WB);
  assign w_raw   = pending_q & (raw_hit(id_rs_use[0], id_rs_fs, tag_q) |
                                raw_hit(id_rs_use[1], id_rs_ft, tag_q));

`ifdef FDIV_BYPASS_EN
  // In WB the quotient is on wb_data this cycle, so dependent reads take it
  // through the forward mux instead of waiting for the regfile.
  assign w_raw_stall = w_raw & ~w_in_wb;
  assign fwd_fs      = w_in_wb & pending_q & raw_hit(id_rs_use[0], id_rs_fs, tag_q);
  assign fwd_ft      = w_in_wb & pending_q & raw_hit(id_rs_use[1], id_rs_ft, tag_q);
`else
  assign w_raw_stall = w_raw;
`endif

  // Only one op may be in flight, so any fdiv outside IDLE waits; this also
  // covers WAW against the pending tag.
  assign stall_id = (id_fdiv & (state_q != S_IDLE)) | w_raw_stall;

  assign div_a   = div_a_q;
  assign div_b   = div_b_q;
  assign div_rm  = div_rm_q;
  assign div_ena = (state_q != S_IDLE);
  assign wb_fd   = w_in_wb ? tag_q : '0;
  assign wb_data = w_in_wb ? div_s : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    tag_d     = tag_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    div_rm_d  = div_rm_q;
    div_fdiv  = 1'b0;
    wb_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (id_fdiv && !w_raw_stall) begin
          div_a_d   = id_a;
          div_b_d   = id_b;
          div_rm_d  = id_rm;
          tag_d     = id_fd;
          pending_d = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        div_fdiv = 1'b1;
        state_d  = S_ITER;
      end
      S_ITER: begin
        // Checked in the entry cycle too, so a divider that never raises
        // busy still moves the op along.
        if (!div_busy) begin
          cnt_d   = CNT_LOAD;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        wb_we     = 1'b1;
        pending_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      tag_q     <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      div_rm_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      tag_q     <= tag_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      div_rm_q  <= div_rm_d;
    end
  end

endmodule : fdiv_issue_ctrl

`default_nettype wire

// File: tb/tb_fdiv_issue_ctrl.sv
// ============================================================================
//  Module  : tb_fdiv_issue_ctrl
//  Purpose : Directed self-checking bench for fdiv_issue_ctrl. The divider
//            is modelled by the bench driving div_busy and div_s directly.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fdiv_issue_ctrl;

  localparam int DRAIN_CYC = 3;
  localparam int TAG_W     = 5;
`ifdef FDIV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             id_fdiv;
  logic [31:0]      id_a, id_b;
  logic [1:0]       id_rm;
  logic [TAG_W-1:0] id_fd, id_rs_fs, id_rs_ft;
  logic [1:0]       id_rs_use;
  logic             div_busy;
  logic [31:0]      div_s;
  logic [31:0]      div_a, div_b;
  logic [1:0]       div_rm;
  logic             div_fdiv, div_ena, stall_id, wb_we;
  logic [TAG_W-1:0] wb_fd;
  logic [31:0]      wb_data;
`ifdef FDIV_BYPASS_EN
  logic             fwd_fs, fwd_ft;
`endif

  int n_vec = 0;
  int n_err = 0;

  fdiv_issue_ctrl #(.DRAIN_CYC(DRAIN_CYC), .TAG_W(TAG_W)) dut (
    .clk(clk), .clr(clr), .id_fdiv(id_fdiv), .id_a(id_a), .id_b(id_b),
    .id_rm(id_rm), .id_fd(id_fd), .id_rs_fs(id_rs_fs), .id_rs_ft(id_rs_ft),
    .id_rs_use(id_rs_use), .div_busy(div_busy), .div_s(div_s),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm), .div_fdiv(div_fdiv),
    .div_ena(div_ena), .stall_id(stall_id), .wb_we(wb_we), .wb_fd(wb_fd),
    .wb_data(wb_data)
`ifdef FDIV_BYPASS_EN
    , .fwd_fs(fwd_fs), .fwd_ft(fwd_ft)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issues one fdiv from IDLE and plays the divider: busy for nbusy ITER
  // cycles, result held on div_s. Reports WB latency counted from START.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [TAG_W-1:0] fd,
                        input logic [31:0] res, input int nbusy,
                        output int lat, output int nwe, output int nst,
                        output logic [TAG_W-1:0] gfd, output logic [31:0] gdata);
    lat = -1; nwe = 0; nst = 0; gfd = '0; gdata = '0;
    id_a = a; id_b = b; id_rm = rm; id_fd = fd; id_fdiv = 1'b1;
    div_s = res; div_busy = 1'b0;
    @(posedge clk); #1;
    id_fdiv = 1'b0;
    for (int k = 0; k < nbusy + 12; k++) begin
      div_busy = (k >= 1) && (k <= nbusy);
      #1;
      if (div_fdiv === 1'b1) nst++;
      if (wb_we === 1'b1) begin
        nwe++;
        if (lat < 0) begin lat = k; gfd = wb_fd; gdata = wb_data; end
      end
      @(posedge clk); #1;
    end
    div_busy = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; id_fdiv = 1'b0; id_a = '0; id_b = '0; id_rm = '0; id_fd = '0;
    id_rs_fs = '0; id_rs_ft = '0; id_rs_use = '0; div_busy = 1'b0; div_s = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({div_a, div_b, div_rm, div_fdiv, div_ena, stall_id, wb_we, wb_fd, wb_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got a=%h b=%h rm=%b st=%b ena=%b stall=%b we=%b fd=%0d data=%h exp all 0",
               div_a, div_b, div_rm, div_fdiv, div_ena, stall_id, wb_we, wb_fd, wb_data);
    end
    // fdiv presented while clr is held must not start anything
    id_fdiv = 1'b1; id_a = 32'h1234_5678;
    @(posedge clk); #1;
    n_vec++;
    if ({div_fdiv, div_ena, div_a} !== '0) begin
      n_err++;
      $display("FAIL reset_hold got st=%b ena=%b a=%h exp 0", div_fdiv, div_ena, div_a);
    end
    id_fdiv = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, nwe, nst; logic [TAG_W-1:0] gfd; logic [31:0] gd;
    run_op(32'h40C0_0000, 32'h4000_0000, 2'd0, 5'd4, 32'h4040_0000, 4, lat, nwe, nst, gfd, gd);
    n_vec++;
    if (nst !== 1) begin n_err++; $display("FAIL basic_start_pulses got=%0d exp=1", nst); end
    n_vec++;
    if (nwe !== 1) begin n_err++; $display("FAIL basic_wb_count got=%0d exp=1", nwe); end
    n_vec++;
    if (gfd !== 5'd4) begin n_err++; $display("FAIL basic_wb_fd got=%0d exp=4", gfd); end
    n_vec++;
    if (gd !== 32'h4040_0000) begin n_err++; $display("FAIL basic_wb_data got=%h exp=40400000", gd); end
    n_vec++;
    if (lat !== 4 + DRAIN_CYC + 2) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", lat, 4 + DRAIN_CYC + 2); end
    n_vec++;
    if ({div_a, div_b} !== {32'h40C0_0000, 32'h4000_0000}) begin
      n_err++; $display("FAIL basic_operands got a=%h b=%h exp 40c00000 40000000", div_a, div_b);
    end
    n_vec++;
    if (div_ena !== 1'b0) begin n_err++; $display("FAIL basic_ena_idle got=%b exp=0", div_ena); end
  endtask

  // op1 (fd=4, busy 2 cycles): START c1, ITER c2-c4, DRAIN c5-c7, WB c8.
  // op2 held from c2, issues in IDLE c9: START c10, ITER c11, DRAIN c12-14, WB c15.
  task automatic test_back_to_back();
    logic es, ew, ef; int nwe;
    nwe = 0;
    for (int c = 0; c <= 17; c++) begin
      id_fdiv   = (c == 0) || (c >= 2 && c <= 9);
      id_a      = (c < 2) ? 32'h4100_0000 : 32'h4200_0000;
      id_b      = 32'h3F80_0000;
      id_rm     = 2'd1;
      id_fd     = (c < 2) ? 5'd4 : 5'd9;
      id_rs_use = 2'b00;
      div_busy  = (c == 2) || (c == 3);
      div_s     = (c < 9) ? 32'h4100_0000 : 32'h4200_0000;
      #1;
      es = (c >= 2 && c <= 8);
      ew = (c == 8) || (c == 15);
      ef = (c == 1) || (c == 10);
      n_vec++;
      if (stall_id !== es) begin n_err++; $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall_id, es); end
      n_vec++;
      if (wb_we !== ew) begin n_err++; $display("FAIL b2b_wb_we c=%0d got=%b exp=%b", c, wb_we, ew); end
      n_vec++;
      if (div_fdiv !== ef) begin n_err++; $display("FAIL b2b_start c=%0d got=%b exp=%b", c, div_fdiv, ef); end
      if (wb_we === 1'b1) nwe++;
      if (c == 8 || c == 15) begin
        n_vec++;
        if ({wb_fd, wb_data} !== ((c == 8) ? {5'd4, 32'h4100_0000} : {5'd9, 32'h4200_0000})) begin
          n_err++; $display("FAIL b2b_wb_payload c=%0d got fd=%0d data=%h", c, wb_fd, wb_data);
        end
      end
      if (c == 10) begin
        n_vec++;
        if (div_a !== 32'h4200_0000) begin n_err++; $display("FAIL b2b_op2_a got=%h exp=42000000", div_a); end
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (nwe !== 2) begin n_err++; $display("FAIL b2b_wb_total got=%0d exp=2", nwe); end
  endtask

  // fd=7, busy 1 cycle: START c1, ITER c2-c3, DRAIN c4-c6, WB c7, IDLE c8.
  task automatic test_raw();
    logic es;
    for (int c = 0; c <= 9; c++) begin
      id_fdiv   = (c == 0);
      id_a      = 32'h4080_0000; id_b = 32'h4000_0000; id_rm = 2'd0; id_fd = 5'd7;
      id_rs_fs  = 5'd7; id_rs_ft = 5'd2; id_rs_use = 2'b01;
      div_busy  = (c == 2);
      div_s     = 32'h4000_0000;
      #1;
      es = (c >= 1 && c <= 6) || (c == 7 && !BYP);
      n_vec++;
      if (stall_id !== es) begin n_err++; $display("FAIL raw_stall c=%0d got=%b exp=%b", c, stall_id, es); end
`ifdef FDIV_BYPASS_EN
      n_vec++;
      if ({fwd_fs, fwd_ft} !== {(c == 7), 1'b0}) begin
        n_err++; $display("FAIL raw_fwd c=%0d got fs=%b ft=%b exp fs=%b ft=0", c, fwd_fs, fwd_ft, (c == 7));
      end
`endif
      if (c == 7) begin
        n_vec++;
        if ({wb_we, wb_fd} !== {1'b1, 5'd7}) begin n_err++; $display("FAIL raw_wb got we=%b fd=%0d exp 1/7", wb_we, wb_fd); end
      end
      @(posedge clk); #1;
    end
    id_rs_use = 2'b00;
  endtask

  // Pending fd=0 never stalls; fd=5 stalls only when the ft read is enabled.
  // busy 0: START c1, ITER c2, DRAIN c3-c5, WB c6.
  task automatic test_no_hazard();
    logic es;
    for (int c = 0; c <= 7; c++) begin
      id_fdiv = (c == 0); id_fd = 5'd0; id_a = 32'h1; id_b = 32'h2; id_rm = 2'd2;
      id_rs_fs = 5'd0; id_rs_ft = 5'd0; id_rs_use = 2'b11; div_busy = 1'b0;
      #1;
      n_vec++;
      if (stall_id !== 1'b0) begin n_err++; $display("FAIL nohaz_r0 c=%0d got=%b exp=0", c, stall_id); end
      @(posedge clk); #1;
    end
    for (int c = 0; c <= 7; c++) begin
      id_fdiv = (c == 0); id_fd = 5'd5;
      id_rs_fs = 5'd5; id_rs_ft = 5'd5;
      id_rs_use = (c == 4) ? 2'b10 : 2'b00;
      #1;
      es = (c == 4);
      n_vec++;
      if (stall_id !== es) begin n_err++; $display("FAIL nohaz_use c=%0d got=%b exp=%b", c, stall_id, es); end
      @(posedge clk); #1;
    end
    id_rs_use = 2'b00;
  endtask

  task automatic test_busy_zero();
    int lat, nwe, nst; logic [TAG_W-1:0] gfd; logic [31:0] gd;
    run_op(32'h3F80_0000, 32'h4040_0000, 2'd3, 5'd12, 32'h3EAA_AAAB, 0, lat, nwe, nst, gfd, gd);
    n_vec++;
    if (lat !== DRAIN_CYC + 2) begin n_err++; $display("FAIL busy0_latency got=%0d exp=%0d", lat, DRAIN_CYC + 2); end
    n_vec++;
    if ({nwe, nst} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL busy0_counts got we=%0d st=%0d exp 1/1", nwe, nst); end
    n_vec++;
    if ({gfd, gd, div_rm} !== {5'd12, 32'h3EAA_AAAB, 2'd3}) begin
      n_err++; $display("FAIL busy0_payload got fd=%0d data=%h rm=%0d exp 12/3eaaaaab/3", gfd, gd, div_rm);
    end
  endtask

  // busy 0: START c1, ITER c2, DRAIN c3 where clr is asserted.
  task automatic test_clr_mid();
    int lat, nwe, nst; logic [TAG_W-1:0] gfd; logic [31:0] gd;
    nwe = 0;
    for (int c = 0; c <= 12; c++) begin
      id_fdiv = (c == 0); id_fd = 5'd3; id_a = 32'hAAAA_0000; id_b = 32'h5555_0000; id_rm = 2'd1;
      div_busy = 1'b0; div_s = 32'hDEAD_BEEF;
      clr = (c == 3);
      #1;
      if (wb_we === 1'b1) nwe++;
      if (c == 4) begin
        n_vec++;
        if ({div_a, div_b, div_rm, div_fdiv, div_ena, stall_id, wb_we, wb_fd, wb_data} !== '0) begin
          n_err++;
          $display("FAIL clr_outputs got a=%h b=%h rm=%b st=%b ena=%b stall=%b we=%b fd=%0d data=%h exp all 0",
                   div_a, div_b, div_rm, div_fdiv, div_ena, stall_id, wb_we, wb_fd, wb_data);
        end
      end
      @(posedge clk); #1;
    end
    clr = 1'b0;
    n_vec++;
    if (nwe !== 0) begin n_err++; $display("FAIL clr_no_wb got=%0d exp=0", nwe); end
    run_op(32'h4110_0000, 32'h4040_0000, 2'd0, 5'd6, 32'h4040_0000, 1, lat, nwe, nst, gfd, gd);
    n_vec++;
    if ({lat, nwe, nst} !== {32'd6, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL clr_fresh_op got lat=%0d we=%0d st=%0d exp 6/1/1", lat, nwe, nst);
    end
    n_vec++;
    if ({gfd, gd} !== {5'd6, 32'h4040_0000}) begin n_err++; $display("FAIL clr_fresh_wb got fd=%0d data=%h exp 6/40400000", gfd, gd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_raw();
    test_no_hazard();
    test_busy_zero();
    test_clr_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fdiv_issue_ctrl

`default_nettype wire
